// File: rtl/stage_if_pkg.sv
// Shared fetch-stage definitions: bus widths, NOP/opcode constants, FSM encodings
// and the RV32I B/J immediate extractors used by the branch predictor.
package stage_if_pkg;

  localparam int InstAddrBus = 32;
  localparam int InstBus     = 32;

  localparam logic [31:0] InstNop      = 32'h0000_0013;
  localparam logic [6:0]  OpcodeBranch = 7'b1100011;
  localparam logic [6:0]  OpcodeJal    = 7'b1101111;

  localparam logic [1:0] IfFetch = 2'd0;
  localparam logic [1:0] IfWait  = 2'd1;
  localparam logic [1:0] IfHold  = 2'd2;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/stage_if_bht.sv
// Branch history table: 2-bit saturating counters plus B/J predecode producing
// a predicted-taken flag and target for the instruction being fetched.
module if_bht
  import stage_if_pkg::*;
#(
  parameter int BHT_INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_upd,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  output logic        o_predict,
  output logic [31:0] o_target
);

  localparam int Entries = 1 << BHT_INDEX_W;

  logic [1:0]             r_cnt [Entries];
  logic [BHT_INDEX_W-1:0] w_rd_idx;
  logic [BHT_INDEX_W-1:0] w_wr_idx;
  logic [6:0]             w_opcode;
  logic                   w_unused_pc;

  assign w_rd_idx    = i_pc[BHT_INDEX_W+1:2];
  assign w_wr_idx    = i_upd_pc[BHT_INDEX_W+1:2];
  assign w_opcode    = i_inst[6:0];
  assign w_unused_pc = ^{i_upd_pc[31:BHT_INDEX_W+2], i_upd_pc[1:0]};

  // The read is combinational off the registered array, so a same-cycle update
  // to the same entry is seen only on the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) r_cnt[i] <= 2'b01;
    end else if (i_upd) begin
      if (i_upd_taken && r_cnt[w_wr_idx] != 2'b11)
        r_cnt[w_wr_idx] <= r_cnt[w_wr_idx] + 2'd1;
      else if (!i_upd_taken && r_cnt[w_wr_idx] != 2'b00)
        r_cnt[w_wr_idx] <= r_cnt[w_wr_idx] - 2'd1;
    end
  end

  always_comb begin
    o_predict = 1'b0;
    o_target  = i_pc + imm_b(i_inst);
    if (w_opcode == OpcodeJal) begin
      o_predict = 1'b1;
      o_target  = i_pc + imm_j(i_inst);
    end else if (w_opcode == OpcodeBranch) begin
      o_predict = r_cnt[w_rd_idx][1];
    end
  end

endmodule

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: PC owner, single-outstanding memory fetch,
// registered decode bundle. Define STAGE_IF_BHT_EN to enable branch prediction.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BHT_INDEX_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        predict_o,
  input  logic        bht_update_i,
  input  logic [31:0] bht_pc_i,
  input  logic        bht_taken_i
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_mem_req;
  logic [31:0] r_mem_addr;
  logic        r_discard;
  logic [31:0] r_hold_inst;
  logic [31:0] r_pc_o;
  logic [31:0] r_inst_o;
  logic        r_valid_o;
  logic        r_predict_o;

  logic [31:0] w_redirect_pc;
  logic        w_resp;
  logic        w_take;
  logic [31:0] w_fetch_inst;
  logic        w_predict;
  logic [31:0] w_next_pc;
  logic        w_unused;

  assign w_redirect_pc = {redirect_pc_i[31:2], 2'b00};
  assign w_resp        = (r_state == IfWait) && mem_ready_i;
  assign w_fetch_inst  = (r_state == IfHold) ? r_hold_inst : mem_data_i;
  // An instruction moves to decode when one is available and neither stall nor redirect blocks it.
  assign w_take        = !redirect_i && !stall_i &&
                         ((w_resp && !r_discard) || (r_state == IfHold));

`ifdef STAGE_IF_BHT_EN
  logic [31:0] w_target;

  if_bht #(.BHT_INDEX_W(BHT_INDEX_W)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pc       (r_pc),
    .i_inst     (w_fetch_inst),
    .i_upd      (bht_update_i),
    .i_upd_pc   (bht_pc_i),
    .i_upd_taken(bht_taken_i),
    .o_predict  (w_predict),
    .o_target   (w_target)
  );

  assign w_next_pc = w_predict ? w_target : r_pc + 32'd4;
  assign w_unused  = ^redirect_pc_i[1:0];
`else
  assign w_predict = 1'b0;
  assign w_next_pc = r_pc + 32'd4;
  assign w_unused  = ^{redirect_pc_i[1:0], bht_update_i, bht_pc_i, bht_taken_i,
                       BHT_INDEX_W[0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IfFetch;
      r_pc        <= RESET_PC;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_discard   <= 1'b0;
      r_pc_o      <= 32'h0;
      r_inst_o    <= InstNop;
      r_valid_o   <= 1'b0;
      r_predict_o <= 1'b0;
    end else begin
      if (w_take) begin
        r_pc_o      <= r_pc;
        r_inst_o    <= w_fetch_inst;
        r_valid_o   <= 1'b1;
        r_predict_o <= w_predict;
      end else if (redirect_i || !stall_i) begin
        r_inst_o    <= InstNop;
        r_valid_o   <= 1'b0;
        r_predict_o <= 1'b0;
      end

      if (redirect_i)  r_pc <= w_redirect_pc;
      else if (w_take) r_pc <= w_next_pc;

      case (r_state)
        IfFetch: begin
          if (!redirect_i) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= IfWait;
          end
        end
        IfWait: begin
          if (mem_ready_i) begin
            r_mem_req <= 1'b0;
            r_discard <= 1'b0;
            if (redirect_i || r_discard || !stall_i) r_state <= IfFetch;
            else                                     r_state <= IfHold;
          end else if (redirect_i) begin
            // The in-flight response must still be consumed, then thrown away.
            r_discard <= 1'b1;
          end
        end
        IfHold: begin
          if (redirect_i || !stall_i) r_state <= IfFetch;
        end
        default: r_state <= IfFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_resp && stall_i) r_hold_inst <= mem_data_i;
  end

  assign mem_req_o  = r_mem_req;
  assign mem_addr_o = r_mem_addr;
  assign pc_o       = r_pc_o;
  assign inst_o     = r_inst_o;
  assign valid_o    = r_valid_o;
  assign predict_o  = r_predict_o;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: per-cycle vector table plus redirect/wrap/BHT sequences.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        predict_o;
  logic        bht_update_i;
  logic [31:0] bht_pc_i;
  logic        bht_taken_i;

  int errors = 0;
  int checks = 0;
  int mem_lat = 1;
  int mem_cnt;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BEQ_P16 = 32'h0000_0863;  // beq x0,x0,+16

  stage_if dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_ready_i(mem_ready_i), .mem_data_i(mem_data_i), .pc_o(pc_o), .inst_o(inst_o),
    .valid_o(valid_o), .predict_o(predict_o), .bht_update_i(bht_update_i),
    .bht_pc_i(bht_pc_i), .bht_taken_i(bht_taken_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_img(input logic [31:0] a);
    return (a == 32'h40) ? BEQ_P16 : a;
  endfunction

  // Memory: answers mem_lat cycles after seeing a request, one response per request.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready_i <= 1'b0;
      mem_data_i  <= 32'h0;
      mem_cnt     <= 0;
    end else if (mem_ready_i) begin
      mem_ready_i <= 1'b0;
      mem_cnt     <= 0;
    end else if (mem_req_o) begin
      if (mem_cnt + 1 >= mem_lat) begin
        mem_ready_i <= 1'b1;
        mem_data_i  <= mem_img(mem_addr_o);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_i = 1'b0;
    redirect_i = 1'b0;
    redirect_pc_i = 32'h0;
    bht_update_i = 1'b0;
    bht_pc_i = 32'h0;
    bht_taken_i = 1'b0;
    mem_lat = 1;
    repeat (2) tick();
    chk("rst.req", mem_req_o, 0);
    chk("rst.addr", mem_addr_o, 0);
    chk("rst.pc", pc_o, 0);
    chk("rst.inst", inst_o, NOP);
    chk("rst.valid", valid_o, 0);
    chk("rst.predict", predict_o, 0);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [14];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    // One row per rising edge after reset release; stall applies to that edge.
    vecs[0]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,  NOP};
    vecs[1]  = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0,  NOP};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0,  NOP};
    vecs[4]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'h0,  NOP};
    vecs[5]  = '{1'b0, 1'b0, 32'h4, 1'b1, 32'h4,  32'h4};
    vecs[6]  = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4,  32'h4};
    vecs[7]  = '{1'b1, 1'b1, 32'h8, 1'b1, 32'h4,  32'h4};
    vecs[8]  = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h4,  32'h4};
    vecs[9]  = '{1'b1, 1'b0, 32'h8, 1'b1, 32'h4,  32'h4};
    vecs[10] = '{1'b0, 1'b0, 32'h8, 1'b1, 32'h8,  32'h8};
    vecs[11] = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0,  NOP};
    vecs[12] = '{1'b0, 1'b1, 32'hC, 1'b0, 32'h0,  NOP};
    vecs[13] = '{1'b0, 1'b0, 32'hC, 1'b1, 32'hC,  32'hC};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      stall_i = vecs[i].stall;
      tick();
      chk($sformatf("vec%0d.req", i), mem_req_o, vecs[i].req);
      chk($sformatf("vec%0d.addr", i), mem_addr_o, vecs[i].addr);
      chk($sformatf("vec%0d.valid", i), valid_o, vecs[i].valid);
      chk($sformatf("vec%0d.inst", i), inst_o, vecs[i].inst);
      if (vecs[i].valid) chk($sformatf("vec%0d.pc", i), pc_o, vecs[i].pc);
    end
    stall_i = 1'b0;

    // Redirect while the request is outstanding; response arrives two cycles later.
    do_reset();
    mem_lat = 3;
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    tick();
    redirect_i = 1'b0;
    chk("rdw.req_held", mem_req_o, 1);
    chk("rdw.addr_held", mem_addr_o, 0);
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      tick();
      chk($sformatf("rdw.valid%0d", c), valid_o, 0);
      if (mem_req_o && mem_addr_o == 32'h100) seen = 1'b1;
    end
    chk("rdw.refetch_seen", {31'b0, seen}, 1);
    mem_lat = 1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      tick();
      if (valid_o) seen = 1'b1;
    end
    chk("rdw.valid_seen", {31'b0, seen}, 1);
    chk("rdw.pc", pc_o, 32'h100);
    chk("rdw.inst", inst_o, 32'h100);

    // Redirect coincides with response while stalled; low address bits ignored.
    do_reset();
    repeat (3) tick();
    chk("rcr.valid0", valid_o, 1);
    stall_i = 1'b1;
    tick();
    chk("rcr.frozen_valid", valid_o, 1);
    chk("rcr.frozen_pc", pc_o, 0);
    chk("rcr.req4", mem_addr_o, 32'h4);
    tick();
    chk("rcr.ready", mem_ready_i, 1);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h203;
    tick();
    redirect_i = 1'b0;
    chk("rcr.valid", valid_o, 0);
    chk("rcr.inst", inst_o, NOP);
    chk("rcr.req_drop", mem_req_o, 0);
    tick();
    chk("rcr.req", mem_req_o, 1);
    chk("rcr.addr", mem_addr_o, 32'h200);
    chk("rcr.stall_valid", valid_o, 0);
    stall_i = 1'b0;

    // PC wrap at the top of the address space.
    do_reset();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    chk("wrap.no_req", mem_req_o, 0);
    tick();
    chk("wrap.addr_top", mem_addr_o, 32'hFFFF_FFFC);
    repeat (2) tick();
    chk("wrap.valid", valid_o, 1);
    chk("wrap.pc", pc_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap.req", mem_req_o, 1);
    chk("wrap.addr0", mem_addr_o, 32'h0);

    // Branch at 0x40 trained taken twice.
    do_reset();
    bht_update_i = 1'b1;
    bht_pc_i = 32'h40;
    bht_taken_i = 1'b1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0;
    tick();
    bht_update_i = 1'b0;
    chk("bht.addr", mem_addr_o, 32'h40);
    repeat (2) tick();
    chk("bht.valid", valid_o, 1);
    chk("bht.inst", inst_o, BEQ_P16);
`ifdef STAGE_IF_BHT_EN
    chk("bht.predict", predict_o, 1);
    tick();
    chk("bht.next_addr", mem_addr_o, 32'h50);
`else
    chk("bht.predict", predict_o, 0);
    tick();
    chk("bht.next_addr", mem_addr_o, 32'h44);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
